// File: rtl/pcu_stack.sv
// Program-counter unit for the 2-stage 4-bit CPU: width-configurable PC, page
// register for jump targets, and a bounded LIFO call/return stack with sticky flags.
module pcu_stack #(
  parameter int ADDR_W      = 12,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_VEC   = 0,
  localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         D_BUS,
  input  logic               cflag,
  input  logic               stall,
  output logic [ADDR_W-1:0]  address,
  output logic               taken,
  output logic [DEPTH_W-1:0] depth,
  output logic               ovf,
  output logic               unf
);

  localparam int PAGE_W = ADDR_W - 4;
  localparam int MEM_N  = 1 << DEPTH_W;

  localparam logic [3:0] OP_JC   = 4'hA;
  localparam logic [3:0] OP_PAGE = 4'hB;
  localparam logic [3:0] OP_CALL = 4'hC;
  localparam logic [3:0] OP_RET  = 4'hD;
  localparam logic [3:0] OP_JNC  = 4'hE;
  localparam logic [3:0] OP_JMP  = 4'hF;

  localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
  localparam logic [ADDR_W-1:0]  PC_ONE     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0]  PC_RESET   = ADDR_W'(RESET_VEC);

  logic [PAGE_W-1:0] page;
  logic [ADDR_W-1:0] stack_mem [0:MEM_N-1];

  logic [3:0]        opcode;
  logic [3:0]        imm;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] target;
  logic [PAGE_W+3:0] page_wide;
  logic [ADDR_W-1:0] top_entry;
  logic              can_push;
  logic              can_pop;

  // The memory is sized to a power of two so depth can index it without truncation.
  always_comb begin
    opcode    = D_BUS[7:4];
    imm       = D_BUS[3:0];
    pc_inc    = address + PC_ONE;
    target    = {page, imm};
    page_wide = {page, imm};
    top_entry = stack_mem[depth - DEPTH_ONE];
    can_push  = (depth != DEPTH_FULL);
    can_pop   = (depth != '0);
  end

  always_ff @(posedge clock) begin
    if (!reset && !stall && opcode == OP_CALL && can_push) begin
      stack_mem[depth] <= pc_inc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      address <= PC_RESET;
      page    <= '0;
      depth   <= '0;
      taken   <= 1'b0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else if (stall) begin
      taken <= 1'b0;
    end else begin
      address <= pc_inc;
      taken   <= 1'b0;
      case (opcode)
        OP_PAGE: page <= page_wide[PAGE_W-1:0];
        OP_JC: begin
          if (cflag) begin
            address <= target;
            taken   <= 1'b1;
          end
        end
        OP_JNC: begin
          if (!cflag) begin
            address <= target;
            taken   <= 1'b1;
          end
        end
        OP_JMP: begin
          address <= target;
          taken   <= 1'b1;
        end
        OP_CALL: begin
          address <= target;
          taken   <= 1'b1;
          if (can_push) depth <= depth + DEPTH_ONE;
          else          ovf   <= 1'b1;
        end
        // A RET on an empty stack falls through to PC+1 without redirecting.
        OP_RET: begin
          if (can_pop) begin
            address <= top_entry;
            depth   <= depth - DEPTH_ONE;
            taken   <= 1'b1;
          end else begin
            unf <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pcu_stack.sv
// Directed testbench for pcu_stack (ADDR_W=12, STACK_DEPTH=4, RESET_VEC=0)
// with hand-computed expected values.
module tb_pcu_stack;

  logic        clock;
  logic        reset;
  logic [7:0]  D_BUS;
  logic        cflag;
  logic        stall;
  logic [11:0] address;
  logic        taken;
  logic [2:0]  depth;
  logic        ovf;
  logic        unf;

  int vectors;
  int miscompares;

  pcu_stack #(.ADDR_W(12), .STACK_DEPTH(4), .RESET_VEC(0)) dut (
    .clock  (clock),
    .reset  (reset),
    .D_BUS  (D_BUS),
    .cflag  (cflag),
    .stall  (stall),
    .address(address),
    .taken  (taken),
    .depth  (depth),
    .ovf    (ovf),
    .unf    (unf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one instruction, let one rising edge pass, then settle before sampling.
  task automatic applyStimulus(input logic [7:0] bus, input logic c, input logic s,
                               input logic r);
    D_BUS = bus;
    cflag = c;
    stall = s;
    reset = r;
    @(posedge clock);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic [11:0] a, input logic t,
                          input logic [2:0] d, input logic o, input logic u);
    checkOutput({tag, ".address"}, 32'(address), 32'(a));
    checkOutput({tag, ".taken"},   32'(taken),   32'(t));
    checkOutput({tag, ".depth"},   32'(depth),   32'(d));
    checkOutput({tag, ".ovf"},     32'(ovf),     32'(o));
    checkOutput({tag, ".unf"},     32'(unf),     32'(u));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    D_BUS = 8'h00; cflag = 1'b0; stall = 1'b0; reset = 1'b1;
    #2;

    applyStimulus(8'h00, 0, 0, 1);
    checkAll("reset", 12'h000, 0, 0, 0, 0);

    // Free run with NOPs: the PC must wrap back to zero after 4096 steps.
    for (int i = 1; i <= 4096; i++) begin
      applyStimulus(8'h00, 0, 0, 0);
      checkOutput("freerun.address", 32'(address), 32'(i % 4096));
      checkOutput("freerun.taken", 32'(taken), 32'd0);
    end

    applyStimulus(8'hB1, 0, 0, 0); checkAll("page1",  12'h001, 0, 0, 0, 0);
    applyStimulus(8'hB2, 0, 0, 0); checkAll("page2",  12'h002, 0, 0, 0, 0);
    applyStimulus(8'hF5, 0, 0, 0); checkAll("jmp",    12'h125, 1, 0, 0, 0);
    applyStimulus(8'h00, 0, 0, 0); checkAll("jmpnop", 12'h126, 0, 0, 0, 0);

    applyStimulus(8'hB0, 0, 0, 0); checkAll("clrpg1", 12'h127, 0, 0, 0, 0);
    applyStimulus(8'hB0, 0, 0, 0); checkAll("clrpg2", 12'h128, 0, 0, 0, 0);
    applyStimulus(8'hE7, 1, 0, 0); checkAll("jnc_c1", 12'h129, 0, 0, 0, 0);
    applyStimulus(8'hE7, 0, 0, 0); checkAll("jnc_c0", 12'h007, 1, 0, 0, 0);
    applyStimulus(8'hA7, 0, 0, 0); checkAll("jc_c0",  12'h008, 0, 0, 0, 0);
    applyStimulus(8'hA7, 1, 0, 0); checkAll("jc_c1",  12'h007, 1, 0, 0, 0);

    applyStimulus(8'hFF, 0, 0, 0); checkAll("to00f",  12'h00F, 1, 0, 0, 0);
    applyStimulus(8'hB4, 0, 0, 0); checkAll("page04", 12'h010, 0, 0, 0, 0);
    applyStimulus(8'hC3, 0, 0, 0); checkAll("call",   12'h043, 1, 1, 0, 0);
    applyStimulus(8'hD0, 0, 0, 0); checkAll("ret",    12'h011, 1, 0, 0, 0);

    applyStimulus(8'hC1, 0, 0, 0); checkAll("nest1",  12'h041, 1, 1, 0, 0);
    applyStimulus(8'hC2, 0, 0, 0); checkAll("nest2",  12'h042, 1, 2, 0, 0);
    applyStimulus(8'hC3, 0, 0, 0); checkAll("nest3",  12'h043, 1, 3, 0, 0);
    applyStimulus(8'hC4, 0, 0, 0); checkAll("nest4",  12'h044, 1, 4, 0, 0);
    applyStimulus(8'hC5, 0, 0, 0); checkAll("nest5",  12'h045, 1, 4, 1, 0);
    applyStimulus(8'hD0, 0, 0, 0); checkAll("unw4",   12'h044, 1, 3, 1, 0);
    applyStimulus(8'hD0, 0, 0, 0); checkAll("unw3",   12'h043, 1, 2, 1, 0);
    applyStimulus(8'hD0, 0, 0, 0); checkAll("unw2",   12'h042, 1, 1, 1, 0);
    applyStimulus(8'hD0, 0, 0, 0); checkAll("unw1",   12'h012, 1, 0, 1, 0);
    applyStimulus(8'hD0, 0, 0, 0); checkAll("unw0",   12'h013, 0, 0, 1, 1);
    applyStimulus(8'h00, 0, 0, 0); checkAll("sticky", 12'h014, 0, 0, 1, 1);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'hF9, 1, 1, 0); checkAll("stall", 12'h014, 0, 0, 1, 1);
    end
    applyStimulus(8'h00, 0, 0, 0); checkAll("unstall", 12'h015, 0, 0, 1, 1);

    applyStimulus(8'hC8, 0, 0, 0); checkAll("pre1",   12'h048, 1, 1, 1, 1);
    applyStimulus(8'hC9, 0, 0, 0); checkAll("pre2",   12'h049, 1, 2, 1, 1);
    applyStimulus(8'hF3, 0, 1, 1); checkAll("rststall", 12'h000, 0, 0, 0, 0);

    applyStimulus(8'hF7, 0, 0, 0); checkAll("pagecleared", 12'h007, 1, 0, 0, 0);
    applyStimulus(8'hD0, 0, 0, 0); checkAll("retempty",    12'h008, 0, 0, 0, 1);

    applyStimulus(8'hBF, 0, 0, 0); checkAll("pgF1",    12'h009, 0, 0, 0, 1);
    applyStimulus(8'hBF, 0, 0, 0); checkAll("pgF2",    12'h00A, 0, 0, 0, 1);
    applyStimulus(8'hFF, 0, 0, 0); checkAll("tofff",   12'hFFF, 1, 0, 0, 1);
    applyStimulus(8'hC0, 0, 0, 0); checkAll("callwrap", 12'hFF0, 1, 1, 0, 1);
    applyStimulus(8'hD0, 0, 0, 0); checkAll("retwrap", 12'h000, 1, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
